// File: rtl/signed_bcd_pkg.sv
// Shared definitions for the signed binary-to-BCD converter.
//   state_e      : converter FSM states
//   DefDinW      : default input word width
//   DefDigits    : default number of BCD output digits
//   min_digits() : smallest digit count able to hold 2^width-1 in BCD
package signed_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned DefDinW   = 8;
  localparam int unsigned DefDigits = 4;

  // Count decimal digits of the largest unsigned value of the given width.
  function automatic int unsigned min_digits(input int unsigned width);
    logic [63:0] v;
    int unsigned d;
    v = (64'd1 << width) - 64'd1;
    d = 0;
    while (v != 64'd0) begin
      v = v / 64'd10;
      d = d + 1;
    end
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
//   digit_i : 4-bit BCD digit before correction
//   digit_o : 4-bit corrected digit
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/signed_bcd_conv.sv
// Sequential signed/unsigned binary to BCD converter (double dabble).
// One iteration per clock; a conversion takes DIN_W cycles in SHIFT followed
// by a single DONE cycle.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : conversion request, sampled only in IDLE
//   is_signed : Din is two's complement when 1, sampled with start
//   Din       : value to convert, sampled with start
//   busy      : high while iterating
//   done      : one-cycle pulse, new Dout/sign valid
//   Dout      : BCD magnitude, least significant digit in [3:0]
//   sign      : result is negative
module signed_bcd_conv
  import signed_bcd_pkg::*;
#(
  parameter int unsigned DIN_W  = DefDinW,
  parameter int unsigned DIGITS = DefDigits
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DIN_W-1:0]      Din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   Dout,
  output logic                  sign
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DIN_W + 1);

  if (DIN_W < 2 || DIN_W > 32) begin : g_bad_width
    $error("signed_bcd_conv: DIN_W must be within 2..32");
  end

  if (DIGITS < min_digits(DIN_W)) begin : g_bad_digits
    $error("signed_bcd_conv: DIGITS too small to hold 2^DIN_W-1 in BCD");
  end

  state_e            state_q, state_d;
  logic [DIN_W-1:0]  mag_q, mag_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [BcdW-1:0]   dout_q, dout_d;
  logic              sign_q, sign_d;

  logic [BcdW-1:0]   bcd_adj;
  logic [BcdW-1:0]   bcd_shift;
  logic [DIN_W-1:0]  mag_shift;
  logic              last_iter;
  logic              din_neg;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  // Corrected accumulator and magnitude shift left together as one register.
  assign bcd_shift = {bcd_adj[BcdW-2:0], mag_q[DIN_W-1]};
  assign mag_shift = {mag_q[DIN_W-2:0], 1'b0};
  assign last_iter = (cnt_q == CntW'(DIN_W - 1));
  assign din_neg   = is_signed & Din[DIN_W-1];

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dout_d  = dout_q;
    sign_d  = sign_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          // Negation kept in DIN_W bits: the most negative value maps to
          // its own bit pattern, which read unsigned is the exact magnitude.
          mag_d   = din_neg ? (~Din + DIN_W'(1)) : Din;
          neg_d   = din_neg;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = bcd_shift;
        mag_d = mag_shift;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          dout_d  = bcd_shift;
          sign_d  = neg_q && (bcd_shift != '0);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dout_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dout_q  <= dout_d;
      sign_q  <= sign_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign Dout = dout_q;
  assign sign = sign_q;

endmodule

// File: tb/tb_signed_bcd_conv.sv
// Directed-vector bench for signed_bcd_conv at DIN_W=8, DIGITS=4.
module tb_signed_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [7:0]  Din;
  logic        busy;
  logic        done;
  logic [15:0] Dout;
  logic        sign;

  int n_checks;
  int n_pass;

  signed_bcd_conv #(
    .DIN_W  (8),
    .DIGITS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .Din       (Din),
    .busy      (busy),
    .done      (done),
    .Dout      (Dout),
    .sign      (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Called one time unit after a rising edge; the next edge accepts.
  // Inputs are scrambled right after acceptance to show they are not re-read.
  task automatic launch(input logic [7:0] d, input logic s);
    Din       = d;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    Din       = ~d;
    is_signed = ~s;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic conv(input string tag, input logic [7:0] d, input logic s,
                      input logic [15:0] exp_dout, input logic exp_sign);
    int lat;
    launch(d, s);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_dout"}, 32'(Dout), 32'(exp_dout));
    check({tag, "_sign"}, 32'(sign), 32'(exp_sign));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    int busy_low;
    int first_at;
    int last_at;
    int gap_bad;
    int val_bad;
    logic [15:0] seen_dout;
    logic        seen_sign;

    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    Din       = '0;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(Dout), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    rst_n = 1'b1;

    // First start right after reset release is accepted on the next edge.
    conv("pos10",   8'd10,  1'b1, 16'h0010, 1'b0);
    conv("neg10",   8'hF6,  1'b1, 16'h0010, 1'b1);
    conv("min",     8'h80,  1'b1, 16'h0128, 1'b1);
    conv("max",     8'h7F,  1'b1, 16'h0127, 1'b0);
    conv("zero",    8'h00,  1'b1, 16'h0000, 1'b0);
    conv("neg1",    8'hFF,  1'b1, 16'h0001, 1'b1);
    conv("uns255",  8'hFF,  1'b0, 16'h0255, 1'b0);
    conv("uns236",  8'hEC,  1'b0, 16'h0236, 1'b0);

    // Start while busy is ignored; outputs hold the previous result.
    launch(8'd20, 1'b1);
    @(posedge clk); #1;
    Din = 8'hFB; is_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rej_hold_dout", 32'(Dout), 32'h0236);
    check("rej_busy", 32'(busy), 32'd1);
    ndone = 0;
    seen_dout = '0;
    seen_sign = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        seen_dout = Dout;
        seen_sign = sign;
      end
    end
    check("rej_ndone", 32'(ndone), 32'd1);
    check("rej_dout", 32'(seen_dout), 32'h0020);
    check("rej_sign", 32'(seen_sign), 32'd0);
    conv("rej_next", 8'hFB, 1'b1, 16'h0005, 1'b1);

    // Reset in the middle of a conversion.
    launch(8'hEC, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mid_hold_dout", 32'(Dout), 32'h0005);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_dout", 32'(Dout), 32'd0);
    check("mid_rst_sign", 32'(sign), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("mid_no_done", 32'(ndone), 32'd0);
    conv("after_rst", 8'd5, 1'b1, 16'h0005, 1'b0);

    // Back-to-back conversions with start held high.
    Din = 8'hEC; is_signed = 1'b1; start = 1'b1;
    ndone = 0; busy_low = 0; first_at = -1; last_at = -1; gap_bad = 0; val_bad = 0;
    for (int s = 0; s < 40; s++) begin
      @(posedge clk); #1;
      if (!busy) busy_low++;
      if (done) begin
        ndone++;
        if (busy) gap_bad++;
        if (Dout !== 16'h0020 || sign !== 1'b1) val_bad++;
        if (first_at < 0) first_at = s;
        else if (s - last_at != 10) gap_bad++;
        last_at = s;
      end
    end
    start = 1'b0;
    check("thr_first", 32'(first_at), 32'd8);
    check("thr_ndone", 32'(ndone), 32'd4);
    check("thr_gap", 32'(gap_bad), 32'd0);
    check("thr_value", 32'(val_bad), 32'd0);
    check("thr_busy_low", 32'(busy_low), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
